// File: rtl/ddr_addr_gen_2d.sv
// Two-level strided DDR address generator: rows x bursts-per-row, each burst
// split into requests of at most MAX_SIZE bytes, issued over valid/ready.
module ddr_addr_gen_2d #(
    parameter int DDR_ADDR_W = 32,
    parameter int BURST_W    = 16,
    parameter int LOOP_W     = 16,
    parameter int MAX_SIZE   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DDR_ADDR_W-1:0] st_addr,
    input  logic [BURST_W-1:0]    burst,
    input  logic [LOOP_W-1:0]     inner_num,
    input  logic [DDR_ADDR_W-1:0] inner_step,
    input  logic [LOOP_W-1:0]     outer_num,
    input  logic [DDR_ADDR_W-1:0] outer_step,
    output logic                  busy,
    output logic                  done,
    output logic [DDR_ADDR_W-1:0] ddr_addr,
    output logic [BURST_W-1:0]    ddr_size,
    output logic                  ddr_last,
    output logic                  ddr_addr_valid,
    input  logic                  ddr_addr_ready
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    localparam logic [BURST_W-1:0]    MAX_SZ   = BURST_W'(MAX_SIZE);
    localparam logic [DDR_ADDR_W-1:0] MAX_STEP = DDR_ADDR_W'(MAX_SIZE);
    localparam logic [LOOP_W-1:0]     ONE_L    = LOOP_W'(1);
    localparam logic [LOOP_W:0]       ONE_LX   = (LOOP_W+1)'(1);

    function automatic logic [BURST_W-1:0] clip_size(input logic [BURST_W-1:0] rem);
        return (rem > MAX_SZ) ? MAX_SZ : rem;
    endfunction

    state_t                state_r, state_s;
    logic [BURST_W-1:0]    burst_r, burst_s, remain_r, remain_s;
    logic [LOOP_W-1:0]     inner_num_r, inner_num_s, outer_num_r, outer_num_s;
    logic [LOOP_W-1:0]     i_r, i_s, o_r, o_s;
    logic [DDR_ADDR_W-1:0] inner_step_r, inner_step_s, outer_step_r, outer_step_s;
    logic [DDR_ADDR_W-1:0] row_base_r, row_base_s, cur_base_r, cur_base_s;
    logic [DDR_ADDR_W-1:0] addr_r, addr_s;
    logic [BURST_W-1:0]    size_r, size_s;
    logic                  last_r, last_s, valid_r, valid_s;
    logic                  done_r, done_s, busy_r, busy_s;
    logic                  hs_s, more_inner_s, more_outer_s;

    assign hs_s         = valid_r && ddr_addr_ready;
    assign more_inner_s = ({1'b0, i_r} + ONE_LX) < {1'b0, inner_num_r};
    assign more_outer_s = ({1'b0, o_r} + ONE_LX) < {1'b0, outer_num_r};

    // Next-state, loop counters, address walk and registered-output preparation
    always_comb begin
        state_s      = state_r;
        burst_s      = burst_r;
        remain_s     = remain_r;
        inner_num_s  = inner_num_r;
        outer_num_s  = outer_num_r;
        inner_step_s = inner_step_r;
        outer_step_s = outer_step_r;
        i_s          = i_r;
        o_s          = o_r;
        row_base_s   = row_base_r;
        cur_base_s   = cur_base_r;
        addr_s       = addr_r;
        valid_s      = 1'b0;
        done_s       = 1'b0;
        busy_s       = busy_r;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
                if (start) begin
                    busy_s = 1'b1;
                    if ((burst != {BURST_W{1'b0}}) && (inner_num != {LOOP_W{1'b0}}) &&
                        (outer_num != {LOOP_W{1'b0}})) begin
                        burst_s      = burst;
                        inner_num_s  = inner_num;
                        outer_num_s  = outer_num;
                        inner_step_s = inner_step;
                        outer_step_s = outer_step;
                        row_base_s   = st_addr;
                        cur_base_s   = st_addr;
                        addr_s       = st_addr;
                        remain_s     = burst;
                        i_s          = {LOOP_W{1'b0}};
                        o_s          = {LOOP_W{1'b0}};
                        valid_s      = 1'b1;
                        state_s      = ST_ISSUE;
                    end else begin
                        done_s  = 1'b1;
                        state_s = ST_FIN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                busy_s  = 1'b1;
                valid_s = 1'b1;
                if (hs_s) begin
                    if (remain_r > MAX_SZ) begin
                        addr_s   = addr_r + MAX_STEP;
                        remain_s = remain_r - MAX_SZ;
                    end else begin
                        remain_s = burst_r;
                        if (more_inner_s) begin
                            i_s        = i_r + ONE_L;
                            cur_base_s = cur_base_r + inner_step_r;
                            addr_s     = cur_base_r + inner_step_r;
                        end else if (more_outer_s) begin
                            i_s        = {LOOP_W{1'b0}};
                            o_s        = o_r + ONE_L;
                            row_base_s = row_base_r + outer_step_r;
                            cur_base_s = row_base_r + outer_step_r;
                            addr_s     = row_base_r + outer_step_r;
                        end else begin
                            valid_s = 1'b0;
                            done_s  = 1'b1;
                            state_s = ST_FIN;
                        end
                    end
                end else begin
                    state_s = ST_ISSUE;
                end
            end
            ST_FIN: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
        // Size and last are computed one cycle ahead so they register with the address
        if (valid_s) begin
            size_s = clip_size(remain_s);
        end else begin
            size_s = size_r;
        end
        last_s = valid_s && (remain_s <= MAX_SZ) &&
                 (i_s == inner_num_s - ONE_L) && (o_s == outer_num_s - ONE_L);
    end

    // State, descriptor and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            burst_r      <= {BURST_W{1'b0}};
            remain_r     <= {BURST_W{1'b0}};
            inner_num_r  <= {LOOP_W{1'b0}};
            outer_num_r  <= {LOOP_W{1'b0}};
            inner_step_r <= {DDR_ADDR_W{1'b0}};
            outer_step_r <= {DDR_ADDR_W{1'b0}};
            i_r          <= {LOOP_W{1'b0}};
            o_r          <= {LOOP_W{1'b0}};
            row_base_r   <= {DDR_ADDR_W{1'b0}};
            cur_base_r   <= {DDR_ADDR_W{1'b0}};
            addr_r       <= {DDR_ADDR_W{1'b0}};
            size_r       <= {BURST_W{1'b0}};
            last_r       <= 1'b0;
            valid_r      <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            burst_r      <= burst_s;
            remain_r     <= remain_s;
            inner_num_r  <= inner_num_s;
            outer_num_r  <= outer_num_s;
            inner_step_r <= inner_step_s;
            outer_step_r <= outer_step_s;
            i_r          <= i_s;
            o_r          <= o_s;
            row_base_r   <= row_base_s;
            cur_base_r   <= cur_base_s;
            addr_r       <= addr_s;
            size_r       <= size_s;
            last_r       <= last_s;
            valid_r      <= valid_s;
            done_r       <= done_s;
            busy_r       <= busy_s;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign ddr_addr       = addr_r;
    assign ddr_size       = size_r;
    assign ddr_last       = last_r;
    assign ddr_addr_valid = valid_r;

endmodule

// File: tb/tb_ddr_addr_gen_2d.sv
// Scoreboard bench for ddr_addr_gen_2d: a nested-loop reference model queues
// the expected request stream, a negedge monitor pops and compares it.
module tb_ddr_addr_gen_2d;

    localparam int MAXS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] st_addr = 32'h0, inner_step = 32'h0, outer_step = 32'h0;
    logic [15:0] burst = 16'h0, inner_num = 16'h0, outer_num = 16'h0;
    logic        ddr_addr_ready = 1'b1;
    logic        busy, done, ddr_last, ddr_addr_valid;
    logic [31:0] ddr_addr;
    logic [15:0] ddr_size;

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_extra = 0;
    logic [48:0] exp_q[$];
    bit          stall_prev = 1'b0;
    logic [48:0] held;

    ddr_addr_gen_2d dut (
        .clk(clk), .rst(rst), .start(start), .st_addr(st_addr), .burst(burst),
        .inner_num(inner_num), .inner_step(inner_step), .outer_num(outer_num),
        .outer_step(outer_step), .busy(busy), .done(done), .ddr_addr(ddr_addr),
        .ddr_size(ddr_size), .ddr_last(ddr_last), .ddr_addr_valid(ddr_addr_valid),
        .ddr_addr_ready(ddr_addr_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Monitor: compare each handshaken request against the scoreboard and check stall stability
    always @(negedge clk) begin
        logic [48:0] e;
        if (rst) begin
            if (stall_prev)
                chk("stall_hold", {ddr_addr_valid, ddr_addr, ddr_size, ddr_last}, {1'b1, held});
            if (ddr_addr_valid && ddr_addr_ready) begin
                if (exp_q.size() == 0) begin
                    n_extra++;
                end else begin
                    e = exp_q.pop_front();
                    chk("req_addr", ddr_addr, e[48:17]);
                    chk("req_size", ddr_size, e[16:1]);
                    chk("req_last", ddr_last, e[0]);
                end
            end
            stall_prev = ddr_addr_valid && !ddr_addr_ready;
            held       = {ddr_addr, ddr_size, ddr_last};
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Reference model pushes the request stream, then the descriptor is presented for one cycle
    task automatic start_job(input logic [31:0] sa, input logic [15:0] b, input logic [15:0] in_n,
                             input logic [31:0] in_s, input logic [15:0] out_n,
                             input logic [31:0] out_s, output int nreq);
        logic [31:0] row, cur, a;
        logic [15:0] rem, sz;
        nreq = 0;
        row  = sa;
        for (int o = 0; o < int'(out_n); o++) begin
            cur = row;
            for (int i = 0; i < int'(in_n); i++) begin
                a   = cur;
                rem = b;
                while (rem != 16'h0) begin
                    sz = (int'(rem) > MAXS) ? 16'(MAXS) : rem;
                    exp_q.push_back({a, sz, (o == int'(out_n) - 1) && (i == int'(in_n) - 1) &&
                                            (int'(rem) <= MAXS)});
                    a   = a + 32'(sz);
                    rem = rem - sz;
                    nreq++;
                end
                cur = cur + in_s;
            end
            row = row + out_s;
        end
        st_addr = sa; burst = b; inner_num = in_n; inner_step = in_s;
        outer_num = out_n; outer_step = out_s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        st_addr = 32'hDEAD_BEE0; burst = 16'h0013; inner_num = 16'h0005;
        inner_step = 32'h0000_0777; outer_num = 16'h0003; outer_step = 32'h0001_2345;
    endtask

    // Run until done (bounded), optionally with random stalls and ignored start pulses
    task automatic wait_done(input string tag, input bit bp, input int nreq);
        int cyc   = 1;
        int stall = 0;
        while (!done) begin
            if (cyc > 3000) begin
                chk({tag, "_timeout_done"}, 64'(done), 64'd1);
                break;
            end
            if (bp) begin
                if (stall > 0) begin
                    ddr_addr_ready = 1'b0;
                    stall--;
                end else if ($urandom_range(0, 2) == 0) begin
                    ddr_addr_ready = 1'b0;
                    stall = int'($urandom_range(2, 4));
                end else begin
                    ddr_addr_ready = 1'b1;
                end
                start = ($urandom_range(0, 3) == 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        ddr_addr_ready = 1'b1;
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
        chk({tag, "_valid_at_done"}, 64'(ddr_addr_valid), 64'd0);
        if (!bp) chk({tag, "_done_cycle"}, 64'(cyc), 64'(nreq + 1));
        chk({tag, "_all_issued"}, 64'(exp_q.size()), 64'd0);
        chk({tag, "_extra_reqs"}, 64'(n_extra), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(done), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(ddr_addr_valid), 64'd0);
        chk("rst_last", 64'(ddr_last), 64'd0);
        chk("rst_addr", 64'(ddr_addr), 64'd0);
        chk("rst_size", 64'(ddr_size), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        start_job(32'h1000, 16'h0100, 16'd3, 32'h400, 16'd1, 32'h0, n);
        chk("one_d_first_addr", 64'(ddr_addr), 64'h1000);
        wait_done("one_d", 1'b0, n);

        start_job(32'h1000, 16'h0250, 16'd1, 32'h0, 16'd1, 32'h0, n);
        wait_done("split", 1'b0, n);

        start_job(32'h0, 16'h0020, 16'd2, 32'h40, 16'd2, 32'h1000, n);
        wait_done("two_d", 1'b0, n);

        start_job(32'h0, 16'h0020, 16'd2, 32'h40, 16'd2, 32'h1000, n);
        wait_done("two_d_bp", 1'b1, n);

        start_job(32'h2000, 16'h0040, 16'd0, 32'h40, 16'd2, 32'h100, n);
        wait_done("zero_inner", 1'b0, n);

        start_job(32'h2000, 16'h0000, 16'd2, 32'h40, 16'd2, 32'h100, n);
        wait_done("zero_burst", 1'b0, n);

        start_job(32'hFFFF_FFC0, 16'h0040, 16'd2, 32'h40, 16'd1, 32'h0, n);
        wait_done("wrap", 1'b0, n);

        start_job(32'h1000, 16'h0100, 16'd3, 32'h400, 16'd1, 32'h0, n);
        @(posedge clk); #1;
        chk("rst_mid_pre_addr", 64'(ddr_addr), 64'h1400);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_valid", 64'(ddr_addr_valid), 64'd0);
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_addr", 64'(ddr_addr), 64'd0);
        chk("rst_mid_size", 64'(ddr_size), 64'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_mid_no_done", 64'(done), 64'd0);
            chk("rst_mid_idle", 64'(busy), 64'd0);
        end

        start_job(32'h8000, 16'h0300, 16'd2, 32'h1000, 16'd2, 32'h10000, n);
        chk("post_rst_first_addr", 64'(ddr_addr), 64'h8000);
        wait_done("post_rst", 1'b1, n);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr_addr_gen_2d.md
# ddr_addr_gen_2d

Two-level strided DDR read/write address generator, the successor to the single-loop burst address generator. It takes one job descriptor and issues a stream of DDR requests (address and size) over a valid/ready handshake. The request stream covers an outer loop of rows, an inner loop of bursts per row, and splitting of each logical burst into chunks no larger than `MAX_SIZE`. It sits between the layer/tile controller and the DDR read/write DMA command port.

## Interface
Parameters:
- `DDR_ADDR_W`, 32: byte address width.
- `BURST_W`, 16: width of burst size and of `ddr_size`.
- `LOOP_W`, 16: width of the inner and outer loop counts.
- `MAX_SIZE`, 256: largest size in bytes of one issued request. Must be ≥1 and < 2^BURST_W.

Ports:
- `clk`  input  1: clock. All logic on the rising edge.
- `rst`  input  1: reset, asynchronous and active-low.
- `start`  input  1: job start. Accepted only when `busy`=0.
- `st_addr`  input  DDR_ADDR_W: byte address of the first burst.
- `burst`  input  BURST_W: logical burst size in bytes.
- `inner_num`  input  LOOP_W: number of bursts per row.
- `inner_step`  input  DDR_ADDR_W: address increment between bursts in a row.
- `outer_num`  input  LOOP_W: number of rows.
- `outer_step`  input  DDR_ADDR_W: address increment between row starts.
- `busy`  output  1: a job is in progress.
- `done`  output  1: one-cycle pulse at the end of a job.
- `ddr_addr`  output  DDR_ADDR_W: request address.
- `ddr_size`  output  BURST_W: request size in bytes.
- `ddr_last`  output  1: marks the final request of the job. Qualified by valid.
- `ddr_addr_valid`  output  1: a request is presented.
- `ddr_addr_ready`  input  1: the consumer accepts the request.

## Operation
- Descriptor inputs are sampled only in the cycle `start` is accepted and are latched internally. Later changes to the inputs have no effect on the running job.
- States: IDLE, ISSUE, FIN.
- IDLE:
  - `start`=1 with `burst`, `inner_num` and `outer_num` all nonzero → latch the descriptor and set `row_base`=`cur_base`=`ddr_addr`=`st_addr`, `remain`=`burst`, `i`=0, `o`=0. Go to ISSUE.
  - `start`=1 with any of those three equal to zero → go to FIN directly. No request is issued.
- ISSUE: `ddr_addr_valid`=1 and `ddr_size`=min(`remain`, `MAX_SIZE`). On each handshake (valid && ready):
  - `remain` > `MAX_SIZE`: `ddr_addr` += `MAX_SIZE`, `remain` -= `MAX_SIZE`.
  - Otherwise the burst is complete and `remain` reloads to `burst`.
    - If `i`+1 < `inner_num`: `i`++, `cur_base` += `inner_step`, `ddr_addr` = new `cur_base`.
    - Else if `o`+1 < `outer_num`: `i`=0, `o`++, `row_base` += `outer_step`, and `cur_base` = `ddr_addr` = new `row_base`.
    - Else go to FIN.
- `ddr_last`=1 exactly when `remain` ≤ `MAX_SIZE`, `i`=`inner_num`-1 and `o`=`outer_num`-1.
- FIN lasts one cycle: `done`=1, then the block returns to IDLE.
- `busy`=1 in ISSUE and FIN. It goes to 0 on the cycle the block re-enters IDLE.
- `start` while `busy`=1 is ignored and does not disturb the running job.
- All address arithmetic is modulo 2^DDR_ADDR_W and wraps silently. There is no 4 KB boundary handling; that is the consumer's job.
- Total requests per job = `inner_num` × `outer_num` × ceil(`burst`/`MAX_SIZE`).

## Timing
- Reset values: `busy`=0, `done`=0, `ddr_addr_valid`=0, `ddr_last`=0, `ddr_addr`=0, `ddr_size`=0, state=IDLE.
- `start` accepted in cycle 0 → `ddr_addr_valid`=1 with the first request in cycle 1.
- With `ddr_addr_ready` held high, one request is accepted per cycle with no bubbles, including across chunk, burst and row transitions.
- While `ddr_addr_valid`=1 and `ddr_addr_ready`=0, `ddr_addr`, `ddr_size` and `ddr_last` hold stable. Valid is never withdrawn before the handshake.
- Handshake on the last request in cycle N:
  - cycle N+1: `ddr_addr_valid`=0 and `done`=1.
  - cycle N+2: `busy`=0, and a new `start` is accepted.
- Zero-count job:
  - `start` in cycle 0 → `done`=1 in cycle 1, with `ddr_addr_valid` never asserted.
  - `busy`=1 in cycle 1 only.
- Asserting `rst` mid-job aborts the job immediately. Outputs return to their reset values asynchronously and no `done` is produced. After deassertion the block sits in IDLE.
- `ddr_addr_ready` is ignored while `ddr_addr_valid`=0.

## Test plan
- 1-D job: `st_addr`=0x1000, `burst`=0x100, `inner_num`=3, `inner_step`=0x400, `outer_num`=1, ready held high → requests (0x1000,0x100), (0x1400,0x100), (0x1800,0x100) in cycles 1–3, `ddr_last` on the third, `done` in cycle 4.
- Chunk split, `MAX_SIZE`=256: `burst`=0x250, `st_addr`=0x1000, loop counts 1/1 → (0x1000,0x100), (0x1100,0x100), (0x1200,0x50) with `ddr_last` on the last.
- 2-D job: `st_addr`=0, `burst`=0x20, `inner_num`=2, `inner_step`=0x40, `outer_num`=2, `outer_step`=0x1000 → addresses 0x0, 0x40, 0x1000, 0x1040, all size 0x20, `ddr_last` only on 0x1040.
- Backpressure on the 2-D job: random `ddr_addr_ready` with ≥3-cycle stalls → identical request sequence, outputs stable during stalls, `start` pulses issued while busy are ignored.
- Zero counts: `inner_num`=0, then `burst`=0 → `done` 1 cycle after `start` and no valid; then wrap-around with `st_addr`=0xFFFF_FFC0, `inner_step`=0x40, `inner_num`=2 → second address 0x0000_0000.
- Reset mid-job: assert `rst` during the second request of the 1-D job → valid drops with no clock edge, no `done`; a new job after release starts cleanly from its own `st_addr`.
